// File: rtl/id_pkg.sv
// Decode-stage shared encodings and default widths.
// Imported by the ID register file and the ID pipeline slot.
package id_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_HI   = 2'b10,
    EXT_BR   = 2'b11
  } ext_e;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LEZ = 3'b010,
    CMP_GTZ = 3'b011,
    CMP_LTZ = 3'b100,
    CMP_GEZ = 3'b101
  } cmp_e;

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file with write-through bypass.
// r0 is hardwired to zero; reset clears every entry in one edge.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0)
      rdata1 = (we && waddr == raddr1) ? wdata : mem[raddr1];
    if (raddr2 != '0)
      rdata2 = (we && waddr == raddr2) ? wdata : mem[raddr2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: one IF slot, operand read/forward, compare, redirect,
// and a valid/ready output register towards EX.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D,
  parameter int NFWD = 3,
  localparam int FSW = $clog2(NFWD + 1),
  localparam int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              stall,
  input  logic              cancel,
  output logic              slot_valid,
  output logic [31:0]       slot_ir,
  input  logic [1:0]        ctl_ext,
  input  logic [2:0]        ctl_cmp,
  input  logic              ctl_branch,
  input  logic              ctl_jump,
  input  logic              ctl_pcd_sel,
  input  logic              ctl_rt_zero,
  input  logic [FSW-1:0]    fwd_rs_sel,
  input  logic [FSW-1:0]    fwd_rt_sel,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ir,
  output logic [XLEN-1:0]   out_pc4,
  output logic [XLEN-1:0]   out_rs,
  output logic [XLEN-1:0]   out_rt,
  output logic [XLEN-1:0]   out_ext,
  output logic              cmp_result,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  logic [XLEN-1:0] slot_pc;
  logic [XLEN-1:0] rf_rs, rf_rt, rs_fwd, rt_fwd;
  logic [XLEN-1:0] pc4, imm_sx, imm_br, ext_val, target;
  logic [AW-1:0]   ra1, ra2;
  logic [15:0]     imm16;
  logic            fire, load, rs_neg, rs_zero;

  // Reset also blocks fire so a mid-transfer reset never redirects.
  assign fire = slot_valid & ~stall & ~cancel & ~reset
              & (~out_valid | out_ready);
  assign in_ready = ~cancel & (~slot_valid | fire);
  assign load = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_ir    <= '0;
      slot_pc    <= '0;
    end else if (cancel) begin
      slot_valid <= 1'b0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_ir    <= in_ir;
      slot_pc    <= in_pc;
    end else if (fire) begin
      slot_valid <= 1'b0;
    end
  end

  assign ra1 = AW'(slot_ir[25:21]);
  assign ra2 = ctl_rt_zero ? '0 : AW'(slot_ir[20:16]);

  id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (ra1),
    .raddr2 (ra2),
    .rdata1 (rf_rs),
    .rdata2 (rf_rt)
  );

  always_comb begin
    rs_fwd = rf_rs;
    rt_fwd = rf_rt;
    for (int k = 1; k <= NFWD; k++) begin
      if (fwd_rs_sel == FSW'(k)) rs_fwd = fwd_data[(k-1)*XLEN +: XLEN];
      if (fwd_rt_sel == FSW'(k)) rt_fwd = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  assign imm16  = slot_ir[15:0];
  assign imm_sx = XLEN'($signed(imm16));
  assign imm_br = imm_sx << 2;

  always_comb begin
    ext_val = '0;
    unique case (ext_e'(ctl_ext))
      EXT_ZERO: ext_val = XLEN'(imm16);
      EXT_SIGN: ext_val = imm_sx;
      EXT_HI:   ext_val = XLEN'(imm16) << 16;
      EXT_BR:   ext_val = imm_br;
    endcase
  end

  assign rs_neg  = rs_fwd[XLEN-1];
  assign rs_zero = (rs_fwd == '0);

  always_comb begin
    cmp_result = 1'b0;
    case (ctl_cmp)
      CMP_EQ:  cmp_result = (rs_fwd == rt_fwd);
      CMP_NE:  cmp_result = (rs_fwd != rt_fwd);
      CMP_LEZ: cmp_result = rs_neg | rs_zero;
      CMP_GTZ: cmp_result = ~rs_neg & ~rs_zero;
      CMP_LTZ: cmp_result = rs_neg;
      CMP_GEZ: cmp_result = ~rs_neg;
      default: cmp_result = 1'b0;
    endcase
  end

  assign pc4 = slot_pc + XLEN'(4);
  assign target = ctl_jump ? {pc4[XLEN-1:28], slot_ir[25:0], 2'b00}
                           : pc4 + imm_br;
  assign redirect_pc = ctl_pcd_sel ? rs_fwd : target;
  assign redirect_valid = fire & (ctl_jump | (ctl_branch & cmp_result));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ir    <= '0;
      out_pc4   <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_ext   <= '0;
    end else if (cancel) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_ir    <= slot_ir;
      out_pc4   <= pc4;
      out_rs    <= rs_fwd;
      out_rt    <= rt_fwd;
      out_ext   <= ext_val;
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
